// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC read path: channel map, default sizes and
// the capture-state encoding used by the read mux.
package rtc_pkg;

    localparam int RTC_W = 8;
    localparam int RTC_N = 14;

    // Channel index map of the RTC register file
    localparam int SEG      = 0;
    localparam int MIN      = 1;
    localparam int HOUR     = 2;
    localparam int DAY      = 3;
    localparam int DATE     = 4;
    localparam int MONTH    = 5;
    localparam int YEAR     = 6;
    localparam int ALM_SEG  = 7;
    localparam int ALM_MIN  = 8;
    localparam int ALM_HOUR = 9;
    localparam int ALM_DAY  = 10;
    localparam int STAT     = 11;
    localparam int CFG      = 12;
    localparam int CTRL     = 13;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } rtc_state_t;

endpackage

// File: rtl/rtc_ptr_ctr.sv
// Read pointer for the holding bank: load, post-increment with wrap, and an
// out-of-range flag computed on the next pointer value.
module rtc_ptr_ctr #(
    parameter  int N     = 14,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sel_load,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             rd_stb,
    input  logic             auto_inc,
    output logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] ptr_next,
    output logic             out_of_range_next
);

    localparam logic [SEL_W-1:0] LAST = SEL_W'(N - 1);

    logic [SEL_W-1:0] ptr_reg;

    always_comb begin
        ptr_next = ptr_reg;
        if (sel_load) begin
            ptr_next = sel_in;
        end else if (rd_stb && auto_inc) begin
            // Anything at or beyond the last channel, including an illegal
            // loaded value, wraps back to channel 0.
            ptr_next = (ptr_reg >= LAST) ? '0 : ptr_reg + SEL_W'(1);
        end
    end

    assign out_of_range_next = (ptr_next > LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    assign ptr = ptr_reg;

endmodule

// File: rtl/rtc_read_mux.sv
// Registered RTC read mux: snapshots all channels into a holding bank and
// serves one byte at a time through a pointer with optional auto-increment.
module rtc_read_mux
    import rtc_pkg::*;
#(
    parameter  int W     = RTC_W,
    parameter  int N     = RTC_N,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             r_s,
    input  logic [N*W-1:0]   ch_bus,
    input  logic             snap,
    input  logic             live,
    input  logic             sel_load,
    input  logic [SEL_W-1:0] sel_in,
    input  logic             rd_stb,
    input  logic             auto_inc,
    output logic [W-1:0]     sal,
    output logic             sal_vld,
    output logic [SEL_W-1:0] sel_cur,
    output logic             err
);

    rtc_state_t       state_reg, state_next;
    logic [W-1:0]     bank_reg  [N];
    logic [W-1:0]     bank_next [N];
    logic [SEL_W-1:0] ptr_next;
    logic             oor_next;
    logic             capture;
    logic [W-1:0]     bank_sel;
    logic [W-1:0]     sal_reg, sal_next;
    logic             sal_vld_reg, sal_vld_next;
    logic             err_reg;

    assign capture = snap | live;

    rtc_ptr_ctr #(.N(N)) u_ptr (
        .clk               (clk),
        .reset_n           (reset_n),
        .sel_load          (sel_load),
        .sel_in            (sel_in),
        .rd_stb            (rd_stb),
        .auto_inc          (auto_inc),
        .ptr               (sel_cur),
        .ptr_next          (ptr_next),
        .out_of_range_next (oor_next)
    );

    always_comb begin
        state_next = state_reg;
        if (state_reg == EMPTY && capture) begin
            state_next = HELD;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_bank
            assign bank_next[gi] = capture ? ch_bus[gi*W +: W] : bank_reg[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    bank_reg[gi] <= '0;
                end else begin
                    bank_reg[gi] <= bank_next[gi];
                end
            end
        end
    endgenerate

    // One-hot select over the post-edge bank so an illegal pointer yields 0
    always_comb begin
        bank_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (ptr_next == SEL_W'(i)) begin
                bank_sel = bank_next[i];
            end
        end
    end

    always_comb begin
        sal_vld_next = r_s && (state_next == HELD) && !oor_next;
        sal_next     = sal_vld_next ? bank_sel : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= EMPTY;
            sal_reg     <= '0;
            sal_vld_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            sal_reg     <= sal_next;
            sal_vld_reg <= sal_vld_next;
            err_reg     <= oor_next;
        end
    end

    assign sal     = sal_reg;
    assign sal_vld = sal_vld_reg;
    assign err     = err_reg;

endmodule
